// File: rtl/sync_1101_pkg.sv
// Shared constants for the 1101-marker serial transmitter: state encoding,
// header pattern and the bit-stuffing history values.
package sync_1101_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    PAY  = 2'b11,
    STF  = 2'b10
  } state_e;

  localparam logic [3:0] HDR_PATTERN = 4'b1101;
  localparam logic [2:0] HIST_INIT   = 3'b101;
  localparam logic [2:0] STUFF_TRIG  = 3'b110;

endpackage

// File: rtl/sync_1101_stuffer.sv
// Tracks the last three bits on the line and flags when the next bit could
// complete a 1101 marker. Present only when STUFF_EN is defined.
`ifdef STUFF_EN
module sync_1101_stuffer
  import sync_1101_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic shift_en,
  input  logic shift_bit,
  output logic stuff_req
);

  logic [2:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (load) begin
      hist_d = HIST_INIT;
    end else if (shift_en) begin
      hist_d = {hist_q[1:0], shift_bit};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign stuff_req = (hist_q == STUFF_TRIG);

endmodule
`endif

// File: rtl/sync_1101_tx.sv
// Serial frame transmitter: 1101 header then W payload bits MSB-first.
// Define STUFF_EN to insert a 0 whenever the payload would form 1101.
module sync_1101_tx
  import sync_1101_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data,
  input  logic         valid,
  output logic         ready,
  output logic         y,
  output logic         en,
  output logic         last
);

  localparam int unsigned BW = $clog2(W) + 1;
  localparam logic [BW-1:0] BITS_INIT = BW'(W);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);

  state_e         state_q, state_d;
  logic [1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [BW-1:0]  bits_left_q, bits_left_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic           y_q, y_d;
  logic           en_q, en_d;
  logic           last_q, last_d;
  logic           emit_pay;
  logic [1:0]     hdr_idx;

  // Output registers always show the bit currently on the line, so each
  // transition computes the bit that appears in the following cycle.
  assign hdr_idx = 2'd2 - hdr_cnt_q;

`ifdef STUFF_EN
  logic emit_stf;
  logic stuff_req;

  sync_1101_stuffer u_stuffer (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == IDLE && valid),
    .shift_en  (emit_pay || emit_stf),
    .shift_bit (y_d),
    .stuff_req (stuff_req)
  );
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    bits_left_d = bits_left_q;
    sreg_d      = sreg_q;
    y_d         = 1'b0;
    en_d        = 1'b0;
    last_d      = 1'b0;
    emit_pay    = 1'b0;
`ifdef STUFF_EN
    emit_stf    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d     = HDR;
          hdr_cnt_d   = 2'd0;
          sreg_d      = data;
          bits_left_d = BITS_INIT;
          y_d         = HDR_PATTERN[3];
          en_d        = 1'b1;
        end
      end
      HDR: begin
        if (hdr_cnt_q != 2'd3) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          y_d       = HDR_PATTERN[hdr_idx];
          en_d      = 1'b1;
        end else begin
          emit_pay = 1'b1;
        end
      end
      PAY: begin
        if (bits_left_q == '0) begin
          state_d = IDLE;
`ifdef STUFF_EN
        end else if (stuff_req) begin
          state_d  = STF;
          emit_stf = 1'b1;
          en_d     = 1'b1;
`endif
        end else begin
          emit_pay = 1'b1;
        end
      end
`ifdef STUFF_EN
      STF: begin
        emit_pay = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit_pay) begin
      state_d     = PAY;
      y_d         = sreg_q[W-1];
      sreg_d      = sreg_q << 1;
      bits_left_d = bits_left_q - BITS_ONE;
      en_d        = 1'b1;
      last_d      = (bits_left_q == BITS_ONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      bits_left_q <= '0;
      sreg_q      <= '0;
      y_q         <= 1'b0;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      bits_left_q <= bits_left_d;
      sreg_q      <= sreg_d;
      y_q         <= y_d;
      en_q        <= en_d;
      last_q      <= last_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign y     = y_q;
  assign en    = en_q;
  assign last  = last_q;

endmodule

// File: tb/tb_sync_1101_tx.sv
// Directed bench for sync_1101_tx (W=8 and W=1 instances); expected frames
// follow the STUFF_EN setting of the build.
module tb_sync_1101_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       ready, y, en, last;
  logic [0:0] data1;
  logic       valid1;
  logic       ready1, y1, en1, last1;

  int checks   = 0;
  int failures = 0;

  logic [63:0] bits;
  int          n, last_pos, nlast, lead;

  always #5 clk = ~clk;

  sync_1101_tx #(.W(8)) u_dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid),
    .ready(ready), .y(y), .en(en), .last(last)
  );

  sync_1101_tx #(.W(1)) u_dut1 (
    .clk(clk), .reset(reset), .data(data1), .valid(valid1),
    .ready(ready1), .y(y1), .en(en1), .last(last1)
  );

`ifdef STUFF_EN
  localparam logic [63:0] EXP_D0 = 64'b1101110010000;
  localparam int          N_D0   = 13;
  localparam logic [63:0] EXP_68 = 64'b1101011001000;
  localparam int          N_68   = 13;
  localparam logic [63:0] EXP_A5 = 64'b1101100100101;
  localparam int          N_A5   = 13;
  localparam logic [63:0] EXP_3C = 64'b1101001111000;
  localparam int          N_3C   = 13;
`else
  localparam logic [63:0] EXP_D0 = 64'b110111010000;
  localparam int          N_D0   = 12;
  localparam logic [63:0] EXP_68 = 64'b110101101000;
  localparam int          N_68   = 12;
  localparam logic [63:0] EXP_A5 = 64'b110110100101;
  localparam int          N_A5   = 12;
  localparam logic [63:0] EXP_3C = 64'b110100111100;
  localparam int          N_3C   = 12;
`endif
  localparam logic [63:0] EXP_06 = 64'b110100000110;
  localparam int          N_06   = 12;
  localparam logic [63:0] EXP_W1 = 64'b11011;
  localparam int          N_W1   = 5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Collects one frame starting at the next falling edge; bounded to 40 cycles.
  task automatic capture(input bit sel);
    logic ye, ee, le;
    bits = '0; n = 0; last_pos = -1; nlast = 0; lead = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ye = sel ? y1 : y;
      ee = sel ? en1 : en;
      le = sel ? last1 : last;
      if (ee) begin
        bits = {bits[62:0], ye};
        n++;
        if (le) begin
          nlast++;
          last_pos = n;
        end
      end else if (n > 0) begin
        break;
      end else begin
        lead++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp, input int exp_n, input bit sel);
    check({tag, " bits"}, bits, exp);
    check({tag, " len"}, 64'(n), 64'(exp_n));
    check({tag, " last_pos"}, 64'(last_pos), 64'(exp_n));
    check({tag, " last_cnt"}, 64'(nlast), 64'd1);
    check({tag, " lead"}, 64'(lead), 64'd0);
    check({tag, " ready_after"}, {63'd0, sel ? ready1 : ready}, 64'd1);
  endtask

  // Handshake at the next rising edge, then scramble data to show it is ignored.
  task automatic send(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~d;
  endtask

  initial begin
    reset = 1'b0; data = 8'hFF; valid = 1'b1; data1 = 1'b0; valid1 = 1'b0;

    // Reset held low with valid asserted: idle outputs, no frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_idle", {60'd0, ready, en, y, last}, 64'b1000);
    end
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {60'd0, ready, en, y, last}, 64'b1000);

    send(8'hD0);
    capture(1'b0);
    check_frame("frame_d0", EXP_D0, N_D0, 1'b0);

    send(8'h68);
    capture(1'b0);
    check_frame("frame_68", EXP_68, N_68, 1'b0);

    send(8'h06);
    capture(1'b0);
    check_frame("frame_06_no_tail_stuff", EXP_06, N_06, 1'b0);

    // Back-to-back: valid stays high, data changes mid-frame.
    data  = 8'hA5;
    valid = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h3C;
    capture(1'b0);
    check_frame("b2b_first", EXP_A5, N_A5, 1'b0);
    check("b2b_gap_en", {63'd0, en}, 64'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 8'h00;
    capture(1'b0);
    check_frame("b2b_second", EXP_3C, N_3C, 1'b0);

    // Reset pulse during payload bit 5 aborts the frame asynchronously.
    send(8'hD0);
    repeat (9) @(negedge clk);
    check("abort_in_frame", {63'd0, en}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_async_drop", {60'd0, ready, en, y, last}, 64'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_held", {61'd0, en, y, last}, 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_recover_ready", {63'd0, ready}, 64'd1);
    send(8'hD0);
    capture(1'b0);
    check_frame("frame_after_abort", EXP_D0, N_D0, 1'b0);

    // W=1 instance: five-bit frame.
    data1  = 1'b1;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data1  = 1'b0;
    capture(1'b1);
    check_frame("w1_frame", EXP_W1, N_W1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_1101_tx.md
# sync_1101_tx

Serial frame transmitter: the sending end of the 1101-marker serial link, driving the single-bit stream that the Mealy 1101 detector consumes. It accepts a parallel payload word through a valid/ready handshake and emits a 4-bit sync header 1101 followed by the payload MSB-first, one bit per clock. Optional bit stuffing guarantees the marker never appears inside the payload. It sits between the parallel data source and the serial line.

## Interface
- W, 8: payload width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 forces idle.
- data  input  W  payload word, sampled on the handshake edge.
- valid  input  1  source has a word on data.
- ready  output  1  transmitter can accept a word; high only in IDLE.
- y  output  1  serial line bit; 0 when not transmitting.
- en  output  1  y carries a frame bit this cycle.
- last  output  1  y carries the final bit of the frame.

## Operation
- States: IDLE, HDR, PAY, STF (2-bit encoding in package).
- IDLE: ready=1, en=0, y=0. On valid&&ready at the clock edge, latch data into the shift register, clear hdr_cnt, go to HDR.
- HDR: emits the header constant 4'b1101 MSB-first over 4 cycles, with hdr_cnt 0..3. After hdr_cnt==3 go to PAY. Load the history register hist[2:0] with 3'b101.
- PAY: emits the shift-register MSB, shifts left, decrements bits_left (width clog2(W)+1, loaded with W). Each emitted bit shifts into hist.
- STF (only with STUFF_EN): emits a forced 0 that does not consume payload. hist updates to {hist[1:0],0}. Return to PAY.
- PAY to STF when hist==3'b110 after an emitted bit and bits_left>0. A stuff bit is never emitted after the final payload bit.
- After the final payload bit, go to IDLE.
- last=1 coincident with the final payload bit; never with a stuff bit.
- data and valid are ignored outside IDLE. The latched word is unaffected by later changes of data.

## Timing
- All outputs are registered except ready, which is decoded from state.
- Reset values: y=0, en=0, last=0, state=IDLE (so ready=1), counters 0, hist 0.
- Latency: the first header bit appears on y in the cycle after the handshake edge.
- Frame length: 4+W cycles, plus one cycle per stuff bit.
- Back-to-back: ready rises the cycle after last. The minimum gap between frames is one cycle with en=0.
- Reset asserted mid-frame aborts immediately: y/en/last drop to 0 asynchronously, no last pulse is generated, and the word is discarded.
- W=1 is legal: the frame is 5 bits and last falls in the fifth cycle.

## Configuration
- STUFF_EN defined: STF state and the hist-based stuffing described above are present.
- STUFF_EN undefined: STF is not reachable and hist logic is removed. The frame is exactly 4+W bits, and the payload may contain 1101.

## Structure
- Package sync_1101_pkg holds:
  - state encoding constants IDLE=2'b00, HDR=2'b01, PAY=2'b11, STF=2'b10;
  - HDR_PATTERN=4'b1101;
  - HIST_INIT=3'b101 and STUFF_TRIG=3'b110.
- One sub-module, sync_1101_stuffer, holds hist and produces the stuff-request flag. It is compiled only under STUFF_EN.

## Test plan
- Reset held low, data=8'hFF, valid=1 -> ready=1, en=0, y=0, last=0 throughout; no frame starts.
- W=8, STUFF_EN off, data=8'hD0 -> y=1101_11010000 over 12 cycles with en=1; last only on cycle 12; ready=1 on cycle 13.
- W=8, STUFF_EN on, data=8'hD0 -> y=1101_110_0_10000 (13 bits, stuff after the third payload bit); last on the final 0; no 1101 inside the payload region.
- STUFF_EN on, data=8'h68 -> y=1101_0110_0_1000 (13 bits). The header-to-payload boundary stuffing uses hist=101.
- valid held high with two queued words -> frames separated by exactly one en=0 cycle; data changes during the frame do not alter the bits emitted.
- reset pulsed low during payload bit 5 -> y/en drop at once and no last; after release, ready=1 and the next handshake gives a complete frame.
